alu_issue_seq: RTL and testbench

- Sequential front end that drives the 64-bit datapath ALU and collects its result.
- Accepts an operation request: ALUOp class, funct fields and two operands.
- Decodes the request into the ALU's 4-bit select code and drives registered A/B/select into the ALU.
- Captures ALU result and zero flag, then returns them over a valid/ready result interface with a branch-taken indication.
- Sits between decode/issue and the combinational ALU.

---
 rtl/alu_issue_seq.sv | 96 +++++++++
 tb/tb_alu_issue_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: sequential issue front end for the combinational 64-bit ALU.
//   clk, reset            : clock and synchronous active-high reset
//   req_valid/req_ready   : request handshake (ALUOp, funct3, funct7_b5, op_a, op_b)
//   A, B, ALU_Sel         : registered operands and select code driven to the ALU
//   ALU_Out, z            : ALU result and zero flag sampled during EXEC
//   res_valid/res_ready   : result handshake (result, zero, branch_taken, illegal)
//   op_count              : number of completed result handshakes (wrapping)
module alu_issue_seq #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       ALUOp,
    input  logic [2:0]       funct3,
    input  logic             funct7_b5,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [3:0]       ALU_Sel,
    input  logic [WIDTH-1:0] ALU_Out,
    input  logic             z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             branch_taken,
    output logic             illegal,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t     state_q;
    logic       br_cls_q;
    logic [3:0] sel_d;
    logic       legal_d;
    // R-type with funct3 000 picks add/sub from funct7_b5; 111/110 ignore it.
    always_comb begin
        sel_d   = ALUOp == 2'b00   ? 4'b0010 :
                  ALUOp == 2'b01   ? 4'b0110 :
                  funct3 == 3'b111 ? 4'b0000 :
                  funct3 == 3'b110 ? 4'b0001 :
                  funct7_b5        ? 4'b0110 : 4'b0010;
        legal_d = !ALUOp[1] || (ALUOp == 2'b10 &&
                  (funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b110));
    end
    assign req_ready = state_q == IDLE;
    assign res_valid = state_q == DONE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            br_cls_q     <= 1'b0;
            A            <= '0;
            B            <= '0;
            ALU_Sel      <= 4'b0010;
            result       <= '0;
            zero         <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
            op_count     <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    br_cls_q <= ALUOp == 2'b01;
                    if (legal_d) begin
                        A       <= op_a;
                        B       <= op_b;
                        ALU_Sel <= sel_d;
                        state_q <= EXEC;
                    end else begin
                        // Illegal requests bypass the ALU and leave its inputs untouched.
                        result       <= '0;
                        zero         <= 1'b0;
                        branch_taken <= 1'b0;
                        illegal      <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                EXEC: begin
                    result       <= ALU_Out;
                    zero         <= z;
                    branch_taken <= br_cls_q & z;
                    illegal      <= 1'b0;
                    state_q      <= DONE;
                end
                DONE: if (res_ready) begin
                    op_count <= op_count + CNT_W'(1);
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: scoreboard bench for alu_issue_seq with a behavioural ALU attached.
module tb_alu_issue_seq;
    typedef struct {
        logic [63:0] res;
        logic        zero;
        logic        br;
        logic        ill;
        logic [3:0]  sel;
        int          lat;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  ALUOp = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic        funct7_b5 = 1'b0;
    logic [63:0] op_a = 64'd0;
    logic [63:0] op_b = 64'd0;
    logic [63:0] A, B, ALU_Out, result;
    logic [3:0]  ALU_Sel;
    logic        z, res_valid, zero, branch_taken, illegal;
    logic        res_ready = 1'b1;
    logic [15:0] op_count;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [3:0]  last_sel = 4'b0010;
    exp_t        sb[$];

    alu_issue_seq #(.WIDTH(64), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .ALUOp(ALUOp), .funct3(funct3), .funct7_b5(funct7_b5), .op_a(op_a), .op_b(op_b),
        .A(A), .B(B), .ALU_Sel(ALU_Sel), .ALU_Out(ALU_Out), .z(z),
        .res_valid(res_valid), .res_ready(res_ready), .result(result), .zero(zero),
        .branch_taken(branch_taken), .illegal(illegal), .op_count(op_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        ALU_Out = 64'hDEAD_BEEF_DEAD_BEEF;
        case (ALU_Sel)
            4'b0000: ALU_Out = A & B;
            4'b0001: ALU_Out = A | B;
            4'b0010: ALU_Out = A + B;
            4'b0110: ALU_Out = A - B;
            default: ;
        endcase
    end
    assign z = ALU_Out == 64'd0;

    function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                   input logic [63:0] a, input logic [63:0] b, input logic [3:0] prev);
        exp_t e;
        logic ok;
        logic [3:0] s;
        ok = 1'b1;
        s = prev;
        if (op == 2'b00) s = 4'b0010;
        else if (op == 2'b01) s = 4'b0110;
        else if (op == 2'b10 && f3 == 3'b000) s = f7 ? 4'b0110 : 4'b0010;
        else if (op == 2'b10 && f3 == 3'b111) s = 4'b0000;
        else if (op == 2'b10 && f3 == 3'b110) s = 4'b0001;
        else ok = 1'b0;
        e.sel = s;
        e.ill = !ok;
        e.res = !ok ? 64'd0 : s == 4'b0010 ? a + b : s == 4'b0110 ? a - b : s == 4'b0000 ? a & b : a | b;
        e.zero = ok && e.res == 64'd0;
        e.br = ok && op == 2'b01 && e.res == 64'd0;
        e.lat = ok ? 2 : 1;
        e.cnt = 16'd0;
        return e;
    endfunction

    task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        e = model(op, f3, f7, a, b, last_sel);
        sb.push_back(e);
        last_sel = e.sel;
        ALUOp = op; funct3 = f3; funct7_b5 = f7; op_a = a; op_b = b;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic collect(output exp_t o);
        o.lat = 1;
        @(negedge clk);
        while (!res_valid && o.lat < 20) begin
            @(negedge clk);
            o.lat++;
        end
        o.res = result; o.zero = zero; o.br = branch_taken; o.ill = illegal; o.sel = ALU_Sel;
        res_ready = 1'b1;
        @(negedge clk);
        o.cnt = op_count;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || ALU_Sel !== 4'b0010 || op_count !== 16'd0 ||
            A !== 64'd0 || B !== 64'd0 || result !== 64'd0 || zero !== 1'b0 || branch_taken !== 1'b0 || illegal !== 1'b0) begin
            n_err++;
            $display("FAIL reset: got rdy=%b vld=%b sel=%b cnt=%0d A=%h B=%h res=%h z=%b br=%b ill=%b, want 1 0 0010 0 zeros",
                     req_ready, res_valid, ALU_Sel, op_count, A, B, result, zero, branch_taken, illegal);
        end
    endtask

    task automatic test_reset_mid;
        send(2'b10, 3'b000, 1'b0, 64'd9, 64'd4);
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_sel = 4'b0010;
        exp_cnt = 16'd0;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (res_valid !== 1'b0 || req_ready !== 1'b1 || op_count !== exp_cnt || ALU_Sel !== 4'b0010) begin
                n_err++;
                $display("FAIL reset_mid[%0d]: got vld=%b rdy=%b cnt=%0d sel=%b, want 0 1 %0d 0010",
                         i, res_valid, req_ready, op_count, ALU_Sel, exp_cnt);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_add;
        exp_t o, e;
        send(2'b10, 3'b000, 1'b0, 64'd5, 64'd7);
        collect(o);
        e = sb.pop_front();
        exp_cnt++;
        n_vec++;
        if (o.res !== 64'd12 || o.res !== e.res || o.zero !== 1'b0 || o.br !== 1'b0 || o.ill !== 1'b0 ||
            o.sel !== 4'b0010 || o.lat !== 2) begin
            n_err++;
            $display("FAIL add: got res=%h z=%b br=%b ill=%b sel=%b lat=%0d, want res=%h z=0 br=0 ill=0 sel=0010 lat=2",
                     o.res, o.zero, o.br, o.ill, o.sel, o.lat, e.res);
        end
        n_vec++;
        if (o.cnt !== exp_cnt) begin
            n_err++;
            $display("FAIL add_count: got %0d want %0d", o.cnt, exp_cnt);
        end
    endtask

    task automatic run_list(input string name, input logic [1:0] op[], input logic [2:0] f3[],
                            input logic f7[], input logic [63:0] a[], input logic [63:0] b[]);
        exp_t o, e;
        for (int i = 0; i < op.size(); i++) begin
            send(op[i], f3[i], f7[i], a[i], b[i]);
            collect(o);
            e = sb.pop_front();
            exp_cnt++;
            n_vec++;
            if (o.res !== e.res || o.zero !== e.zero || o.br !== e.br || o.ill !== e.ill ||
                o.sel !== e.sel || o.lat !== e.lat || o.cnt !== exp_cnt) begin
                n_err++;
                $display("FAIL %s[%0d]: got res=%h z=%b br=%b ill=%b sel=%b lat=%0d cnt=%0d, want res=%h z=%b br=%b ill=%b sel=%b lat=%0d cnt=%0d",
                         name, i, o.res, o.zero, o.br, o.ill, o.sel, o.lat, o.cnt,
                         e.res, e.zero, e.br, e.ill, e.sel, e.lat, exp_cnt);
            end
        end
    endtask

    task automatic test_branch;
        exp_t o;
        send(2'b01, 3'b000, 1'b0, 64'h1234, 64'h1234);
        collect(o);
        void'(sb.pop_front());
        exp_cnt++;
        n_vec++;
        if (o.res !== 64'd0 || o.zero !== 1'b1 || o.br !== 1'b1 || o.sel !== 4'b0110 || o.lat !== 2) begin
            n_err++;
            $display("FAIL branch_eq: got res=%h z=%b br=%b sel=%b lat=%0d, want 0 1 1 0110 2", o.res, o.zero, o.br, o.sel, o.lat);
        end
        send(2'b01, 3'b000, 1'b0, 64'h1234, 64'h1235);
        collect(o);
        void'(sb.pop_front());
        exp_cnt++;
        n_vec++;
        if (o.res !== 64'hFFFF_FFFF_FFFF_FFFF || o.zero !== 1'b0 || o.br !== 1'b0 || o.cnt !== exp_cnt) begin
            n_err++;
            $display("FAIL branch_ne: got res=%h z=%b br=%b cnt=%0d, want ffffffffffffffff 0 0 %0d", o.res, o.zero, o.br, o.cnt, exp_cnt);
        end
    endtask

    task automatic test_logic;
        run_list("logic", '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00},
                          '{3'b111, 3'b110, 3'b000, 3'b111, 3'b101},
                          '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1},
                          '{64'hF0F0, 64'hF0F0, 64'd0, 64'hFF00, 64'hFFFF_FFFF_FFFF_FFFF},
                          '{64'h0FF0, 64'h0FF0, 64'd1, 64'h00FF, 64'd1});
    endtask

    task automatic test_illegal;
        run_list("illegal", '{2'b10, 2'b11, 2'b10, 2'b10, 2'b10},
                            '{3'b110, 3'b000, 3'b001, 3'b010, 3'b111},
                            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
                            '{64'd3, 64'd8, 64'd8, 64'd1, 64'hF},
                            '{64'd5, 64'd8, 64'd2, 64'd1, 64'h3});
    endtask

    task automatic test_backpressure;
        exp_t o, e;
        res_ready = 1'b0;
        send(2'b10, 3'b000, 1'b0, 64'd100, 64'd23);
        for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
        e = sb.pop_front();
        ALUOp = 2'b01; funct3 = 3'b000; funct7_b5 = 1'b0; op_a = 64'h77; op_b = 64'h77;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (req_ready !== 1'b0 || res_valid !== 1'b1 || result !== e.res || result !== 64'd123 ||
                illegal !== 1'b0 || A !== 64'd100 || ALU_Sel !== 4'b0010 || op_count !== exp_cnt) begin
                n_err++;
                $display("FAIL backpressure[%0d]: got rdy=%b vld=%b res=%h ill=%b A=%h sel=%b cnt=%0d, want 0 1 %h 0 64 0010 %0d",
                         i, req_ready, res_valid, result, illegal, A, ALU_Sel, op_count, e.res, exp_cnt);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        n_vec++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || op_count !== exp_cnt || A !== 64'd100) begin
            n_err++;
            $display("FAIL release: got rdy=%b vld=%b cnt=%0d A=%h, want 1 0 %0d 64", req_ready, res_valid, op_count, A, exp_cnt);
        end
        send(2'b01, 3'b000, 1'b0, 64'h77, 64'h77);
        n_vec++;
        if (req_ready !== 1'b0 || A !== 64'h77 || ALU_Sel !== 4'b0110) begin
            n_err++;
            $display("FAIL post_release_accept: got rdy=%b A=%h sel=%b, want 0 77 0110", req_ready, A, ALU_Sel);
        end
        collect(o);
        e = sb.pop_front();
        exp_cnt++;
        n_vec++;
        if (o.res !== e.res || o.zero !== 1'b1 || o.br !== 1'b1 || o.lat !== 2 || o.cnt !== exp_cnt) begin
            n_err++;
            $display("FAIL post_release_op: got res=%h z=%b br=%b lat=%0d cnt=%0d, want %h 1 1 2 %0d",
                     o.res, o.zero, o.br, o.lat, o.cnt, e.res, exp_cnt);
        end
    endtask

    task automatic test_back_to_back;
        exp_t o, e;
        logic [63:0] a, b;
        for (int i = 0; i < 30; i++) begin
            a = {$urandom(), $urandom()};
            b = $urandom_range(0, 3) == 0 ? a : {$urandom(), $urandom()};
            send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), a, b);
            collect(o);
            e = sb.pop_front();
            exp_cnt++;
            n_vec++;
            if (o.res !== e.res || o.zero !== e.zero || o.br !== e.br || o.ill !== e.ill ||
                o.sel !== e.sel || o.lat !== e.lat || o.cnt !== exp_cnt) begin
                n_err++;
                $display("FAIL random[%0d]: got res=%h z=%b br=%b ill=%b sel=%b lat=%0d cnt=%0d, want res=%h z=%b br=%b ill=%b sel=%b lat=%0d cnt=%0d",
                         i, o.res, o.zero, o.br, o.ill, o.sel, o.lat, o.cnt,
                         e.res, e.zero, e.br, e.ill, e.sel, e.lat, exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset;
        test_reset_mid;
        test_add;
        test_branch;
        test_logic;
        test_illegal;
        test_backpressure;
        test_back_to_back;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
